// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed multiply (radix-2 shift-add) / restoring divide, one bit per cycle.
// Optional MULTDIV_ZERO_SHORTCUT_EN: zero multiply operand or zero divisor skips iteration.
module multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [TAGW-1:0]  ctrl_destReg,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic [TAGW-1:0]  out_destReg,
  output logic             busy
);

  localparam int ITER = WIDTH;
  localparam int CW   = $clog2(ITER);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               neg_q, neg_d;
  logic               is_mul_q, is_mul_d;
  logic               divz_q, divz_d;
  logic               skip_q, skip_d;
  logic [TAGW-1:0]    tag_q, tag_d;
  logic [TAGW-1:0]    out_tag_q, out_tag_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               exc_q, exc_d;
  logic               rdy_q, rdy_d;

  logic               start, last, skip_start;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     add_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_step, div_step, prod_s;
  logic [WIDTH-1:0]   quo_s;

  assign start = ctrl_MULT | ctrl_DIV;
  assign last  = (cnt_q == CW'(ITER - 1));
  assign abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

`ifdef MULTDIV_ZERO_SHORTCUT_EN
  assign skip_start = ctrl_MULT ? ((data_operandA == '0) || (data_operandB == '0))
                                : (data_operandB == '0);
`else
  assign skip_start = 1'b0;
`endif

  // acc holds {partial product high, multiplier/product low} or {remainder, dividend/quotient}
  assign add_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_step  = {add_sum, acc_q[WIDTH-1:1]};
  assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign div_step  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
  assign prod_s    = neg_q ? -acc_q : acc_q;
  assign quo_s     = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      neg_q     <= 1'b0;
      is_mul_q  <= 1'b0;
      divz_q    <= 1'b0;
      skip_q    <= 1'b0;
      tag_q     <= '0;
      out_tag_q <= '0;
      res_q     <= '0;
      exc_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      neg_q     <= neg_d;
      is_mul_q  <= is_mul_d;
      divz_q    <= divz_d;
      skip_q    <= skip_d;
      tag_q     <= tag_d;
      out_tag_q <= out_tag_d;
      res_q     <= res_d;
      exc_q     <= exc_d;
      rdy_q     <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ctrl_MULT) begin
      state_d = MUL;
    end else if (ctrl_DIV) begin
      state_d = DIV;
    end else begin
      case (state_q)
        MUL, DIV: if (last || skip_q) state_d = DONE;
        DONE:     state_d = IDLE;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    neg_d     = neg_q;
    is_mul_d  = is_mul_q;
    divz_d    = divz_q;
    skip_d    = skip_q;
    tag_d     = tag_q;
    out_tag_d = out_tag_q;
    res_d     = res_q;
    exc_d     = exc_q;
    rdy_d     = 1'b0;
    if (start) begin
      // A start in any state restarts; multiply wins a collision
      is_mul_d = ctrl_MULT;
      acc_d    = {{WIDTH{1'b0}}, ctrl_MULT ? abs_b : abs_a};
      opb_d    = ctrl_MULT ? abs_a : abs_b;
      neg_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      divz_d   = (data_operandB == '0);
      skip_d   = skip_start;
      tag_d    = ctrl_destReg;
      cnt_d    = '0;
    end else begin
      case (state_q)
        MUL, DIV: begin
          cnt_d = last ? '0 : cnt_q + CW'(1);
          if (skip_q)              acc_d = '0;
          else if (state_q == MUL) acc_d = mul_step;
          else                     acc_d = div_step;
        end
        DONE: begin
          rdy_d     = 1'b1;
          out_tag_d = tag_q;
          if (is_mul_q) begin
            res_d = prod_s[WIDTH-1:0];
            exc_d = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
          end else if (divz_q) begin
            res_d = '0;
            exc_d = 1'b1;
          end else begin
            res_d = quo_s;
            exc_d = !neg_q && acc_q[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign out_destReg    = out_tag_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed vector bench for multdiv_unit; expected latency follows MULTDIV_ZERO_SHORTCUT_EN.
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic [4:0]  ctrl_destReg;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;
  logic [4:0]  out_destReg;

  int checks = 0;
  int errors = 0;

  multdiv_unit #(.WIDTH(32), .TAGW(5)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB), .ctrl_destReg(ctrl_destReg),
    .data_result(data_result), .data_exception(data_exception), .data_resultRDY(data_resultRDY),
    .out_destReg(out_destReg), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          mul;
    logic [31:0] a, b;
    logic [4:0]  tag;
    logic [31:0] res;
    bit          exc;
    int          lat;
  } vec_t;

  vec_t vecs[14];

`ifdef MULTDIV_ZERO_SHORTCUT_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 33;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start pulse is applied for exactly one rising edge; returns at the negedge after it
  task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag);
    @(negedge clock);
    ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b; ctrl_destReg = tag;
    @(negedge clock);
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = 32'hDEAD_BEEF; data_operandB = 32'h1234_5678; ctrl_destReg = 5'd31;
  endtask

  task automatic wait_rdy(output int lat, output int busy_cnt);
    lat = -1;
    busy_cnt = busy ? 1 : 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      if (busy) busy_cnt++;
      if (data_resultRDY) begin
        lat = k;
        break;
      end
    end
  endtask

  function automatic vec_t mk(bit m, logic [31:0] a, logic [31:0] b, logic [4:0] tag,
                              logic [31:0] res, bit exc, int lat);
    vec_t v;
    v.mul = m; v.a = a; v.b = b; v.tag = tag; v.res = res; v.exc = exc; v.lat = lat;
    return v;
  endfunction

  initial begin
    int lat, bcnt;
    logic [31:0] held;
    bit seen;

    vecs[0]  = mk(1, 32'd7,        -32'sd6,      5'd3,  32'hFFFF_FFD6, 0, 33);
    vecs[1]  = mk(1, 32'h0001_0000, 32'h0001_0000, 5'd4, 32'h0000_0000, 1, 33);
    vecs[2]  = mk(0, -32'sd100,     32'd7,        5'd7,  32'hFFFF_FFF2, 0, 33);
    vecs[3]  = mk(0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 1, 33);
    vecs[4]  = mk(0, 32'd5,         32'd0,        5'd9,  32'h0000_0000, 1, ZLAT);
    vecs[5]  = mk(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'h0000_0001, 0, 33);
    vecs[6]  = mk(1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1, 33);
    vecs[7]  = mk(1, 32'd0,         32'd12345,    5'd12, 32'h0000_0000, 0, ZLAT);
    vecs[8]  = mk(0, 32'd100,       -32'sd7,      5'd13, 32'hFFFF_FFF2, 0, 33);
    vecs[9]  = mk(0, -32'sd7,       -32'sd2,      5'd14, 32'h0000_0003, 0, 33);
    vecs[10] = mk(1, 32'h7FFF_FFFF, 32'd2,        5'd15, 32'hFFFF_FFFE, 1, 33);
    vecs[11] = mk(1, -32'sd3,       32'h4000_0000, 5'd16, 32'h4000_0000, 1, 33);
    vecs[12] = mk(0, 32'd3,         32'd5,        5'd0,  32'h0000_0000, 0, 33);
    vecs[13] = mk(0, 32'h8000_0000, 32'd1,        5'd17, 32'h8000_0000, 0, 33);

    ctrl_MULT = 0; ctrl_DIV = 0; data_operandA = 0; data_operandB = 0; ctrl_destReg = 0;
    ctrl_reset = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_rdy", 64'(data_resultRDY), 64'd0);
    check("reset_result", 64'(data_result), 64'd0);
    check("reset_exc", 64'(data_exception), 64'd0);
    check("reset_tag", 64'(out_destReg), 64'd0);
    ctrl_reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      start_op(vecs[i].mul, !vecs[i].mul, vecs[i].a, vecs[i].b, vecs[i].tag);
      wait_rdy(lat, bcnt);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("v%0d_busy_cycles", i), 64'(bcnt), 64'(vecs[i].lat));
      check($sformatf("v%0d_result", i), 64'(data_result), 64'(vecs[i].res));
      check($sformatf("v%0d_exc", i), 64'(data_exception), 64'(vecs[i].exc));
      check($sformatf("v%0d_tag", i), 64'(out_destReg), 64'(vecs[i].tag));
      @(negedge clock);
      check($sformatf("v%0d_rdy_one_cycle", i), 64'(data_resultRDY), 64'd0);
      check($sformatf("v%0d_hold", i), 64'(data_result), 64'(vecs[i].res));
    end

    // Divide start 10 cycles into a multiply aborts the multiply
    start_op(1, 0, 32'd3, 32'd4, 5'd1);
    seen = 0;
    repeat (10) begin
      @(negedge clock);
      if (data_resultRDY) seen = 1;
    end
    check("restart_no_mul_rdy", 64'(seen), 64'd0);
    start_op(0, 1, 32'd20, 32'd5, 5'd2);
    wait_rdy(lat, bcnt);
    check("restart_latency", 64'(lat), 64'd33);
    check("restart_result", 64'(data_result), 64'd4);
    check("restart_tag", 64'(out_destReg), 64'd2);

    // Both starts on one edge: multiply wins (6*3=18, divide would give 2)
    start_op(1, 1, 32'd6, 32'd3, 5'd9);
    wait_rdy(lat, bcnt);
    check("collide_latency", 64'(lat), 64'd33);
    check("collide_result", 64'(data_result), 64'd18);
    check("collide_tag", 64'(out_destReg), 64'd9);
    @(negedge clock);
    check("collide_single_rdy", 64'(data_resultRDY), 64'd0);

    // Asynchronous reset partway through a divide
    start_op(0, 1, 32'd1000, 32'd3, 5'd6);
    repeat (15) @(negedge clock);
    held = data_result;
    check("pre_reset_result_held", 64'(held), 64'd18);
    #2 ctrl_reset = 1'b1;
    #1;
    check("async_reset_busy", 64'(busy), 64'd0);
    check("async_reset_rdy", 64'(data_resultRDY), 64'd0);
    check("async_reset_result", 64'(data_result), 64'd0);
    check("async_reset_tag", 64'(out_destReg), 64'd0);
    @(negedge clock);
    ctrl_reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY || busy) seen = 1;
    end
    check("no_rdy_after_reset", 64'(seen), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Iterative signed 32-bit multiply/divide unit in the execute stage.
- Consumes the operand pair read from the register file and produces a writeback value plus destination tag for the register-file write port.
- Multi-cycle, single outstanding operation, start-pulse / ready-pulse handshake.
- Multiply is radix-2 shift-add; divide is restoring, one bit per cycle.

Parameters:
WIDTH, 32, operand and result width; ITER = WIDTH iterations per operation
TAGW, 5, destination register tag width (matches register-file address width)

Ports:
clock  input  1  rising-edge clock
ctrl_reset  input  1  asynchronous, active-high reset
ctrl_MULT  input  1  start pulse for signed multiply, sampled on rising edge
ctrl_DIV  input  1  start pulse for signed divide, sampled on rising edge
data_operandA  input  WIDTH  multiplicand / dividend
data_operandB  input  WIDTH  multiplier / divisor
ctrl_destReg  input  TAGW  destination register tag, latched at start
data_result  output  WIDTH  low WIDTH bits of product, or quotient
data_exception  output  1  overflow or divide-by-zero flag, valid with data_resultRDY
data_resultRDY  output  1  one-cycle pulse: result valid
out_destReg  output  TAGW  latched tag, valid with data_resultRDY
busy  output  1  high while an operation is in flight

Behaviour:
- Reset is asynchronous; clock is clock. On ctrl_reset all of the following are 0 and the FSM goes to IDLE: data_result, data_exception, data_resultRDY, out_destReg, busy, counter, internal registers.
- FSM states: IDLE, MUL, DIV, DONE.
- Start:
  - Edge where ctrl_MULT=1 → MUL; edge where ctrl_DIV=1 → DIV.
  - Both high on the same edge → multiply wins; the divide is dropped.
  - Operands and ctrl_destReg are latched on the start edge; the counter is cleared.
- Restart: a start sampled in MUL, DIV or DONE aborts the current operation without a ready pulse and restarts with the new operands.
- Iteration: MUL and DIV run exactly ITER cycles; the counter wraps from ITER-1 to DONE.
- Timing:
  - busy is high from the edge after start through the DONE cycle.
  - data_resultRDY is high for exactly one cycle, entered after the (ITER+1)th rising edge following the start edge (33 for WIDTH=32).
  - DONE → IDLE on the next edge.
- Multiply:
  - Signed two's-complement operands, 2*WIDTH-bit product.
  - data_result = low WIDTH bits.
  - data_exception = 1 iff the high WIDTH bits are not the sign extension of bit WIDTH-1.
- Divide:
  - Magnitudes are divided unsigned; the quotient is truncated toward zero and negated when the operand signs differ. No remainder output.
  - Divisor 0 → data_result=0, data_exception=1.
  - -2^(WIDTH-1) / -1 → data_result=0x80000000, data_exception=1.
- Hold: data_result, data_exception and out_destReg hold their values after DONE until the next start is sampled.
- Inputs are ignored while busy, except for start pulses (see Restart).
- Downstream contract: writeback to the register file uses data_resultRDY as write enable and out_destReg as write address. Tag 0 produces a normal ready pulse; the register file discards the write.

Optional Feature:
- Macro: MULTDIV_ZERO_SHORTCUT_EN.
- Defined:
  - A multiply with either operand 0, or a divide with divisor 0, skips iteration and enters DONE on the edge after the start edge (data_resultRDY 2 cycles after start).
  - Multiply gives result 0, exception 0; divide-by-zero gives result 0, exception 1.
- Undefined: every operation takes the full ITER iterations.

Test Plan:
- Multiply: ctrl_MULT pulse, A=7, B=-6, tag 3 → after 33 edges, one-cycle data_resultRDY with data_result=0xFFFFFFD6, exception 0, out_destReg=3; busy high for 33 cycles.
- Multiply overflow: A=0x00010000, B=0x00010000 → data_result=0x00000000, data_exception=1.
- Divide: ctrl_DIV, A=-100, B=7 → data_result=0xFFFFFFF2 (-14), exception 0. Then A=0x80000000, B=-1 → data_result=0x80000000, exception 1.
- Divide by zero: A=5, B=0 → data_result=0, exception 1. Ready after 33 edges without MULTDIV_ZERO_SHORTCUT_EN, after 2 edges with it.
- Restart and collision: ctrl_MULT (A=3, B=4), then ctrl_DIV (A=20, B=5) 10 cycles later → no ready for the multiply; ready 33 edges after the divide start with data_result=4. Both starts high in the same cycle → multiply result only.
- Reset mid-operation: assert ctrl_reset asynchronously 15 cycles into a divide → busy, data_resultRDY, data_result and out_destReg are 0 immediately, and no ready pulse follows after release.
